// File: rtl/hex2dec_pkg.sv
// hex2dec_pkg: shared state type and constants for the counting binary-to-BCD converter
package hex2dec_pkg;
    typedef enum logic {LOAD, COUNT} state_t;
    localparam int NDIG = 4;
    localparam logic [3:0] BCD_MAX = 4'd9;
endpackage

// File: rtl/hex2dec_bcd_decade.sv
// bcd_decade: one 0..9 wrapping BCD counter stage with terminal count and carry out
module bcd_decade
    import hex2dec_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       ce_in,
    output logic [3:0] q,
    output logic       tc,
    output logic       ceo
);
    assign tc  = (q == BCD_MAX);
    assign ceo = ce_in & tc;
    // digit clears at the start of a conversion, otherwise counts and wraps 9 -> 0
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            q <= 4'd0;
        else if (clr)
            q <= 4'd0;
        else if (ce_in)
            q <= tc ? 4'd0 : q + 4'd1;
    end
endmodule

// File: rtl/hex2dec.sv
// hex2dec: 16-bit binary to 4-digit packed BCD by counting a down-counter to zero
module hex2dec
    import hex2dec_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        CE,
    input  logic [15:0] I,
    output logic [15:0] O,
    output logic [15:0] B,
    output logic [3:0]  TC,
    output logic [3:0]  CEO
);
    state_t          state;
    logic [15:0]     digits;
    logic [NDIG-1:0] ce_chain;
    logic            en0;
    logic            clr;
    assign en0 = CE & (state == COUNT) & (B != 16'd0);
    assign clr = CE & (state == LOAD);
    // each decade is enabled when every lower decade carries; same as CEO of the one below
    assign ce_chain = {en0 & (&TC[2:0]), en0 & (&TC[1:0]), en0 & TC[0], en0};
    for (genvar g = 0; g < NDIG; g++) begin : g_dec
        bcd_decade u_dec (
            .clk   (clk),
            .rst   (rst),
            .clr   (clr),
            .ce_in (ce_chain[g]),
            .q     (digits[4*g +: 4]),
            .tc    (TC[g]),
            .ceo   (CEO[g])
        );
    end
    // controller: load the down-counter, count it to zero, then latch the digit chain
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= LOAD;
            B     <= 16'd0;
            O     <= 16'd0;
        end else if (CE) begin
            if (state == LOAD) begin
                B     <= I;
                state <= COUNT;
            end else if (B != 16'd0) begin
                B <= B - 16'd1;
            end else begin
                O     <= digits;
                state <= LOAD;
            end
        end
    end
endmodule

// File: tb/tb_hex2dec.sv
// tb_hex2dec: table-driven conversions with a result scoreboard plus CE-pause and reset corner cases
module tb_hex2dec;
    logic        clk = 1'b0;
    logic        rst;
    logic        CE;
    logic [15:0] I;
    logic [15:0] O;
    logic [15:0] B;
    logic [3:0]  TC;
    logic [3:0]  CEO;
    int          checks = 0;
    int          errors = 0;
    logic [15:0] last_o;
    logic [15:0] sb[$];

    typedef struct {
        logic [15:0] i;
        logic [15:0] o;
    } vec_t;
    vec_t vecs[11];

    hex2dec dut (
        .clk (clk),
        .rst (rst),
        .CE  (CE),
        .I   (I),
        .O   (O),
        .B   (B),
        .TC  (TC),
        .CEO (CEO)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] bcd(input int x);
        int v;
        v = x % 10000;
        return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    function automatic logic [3:0] exp_tc(input logic [15:0] d);
        logic [3:0] r;
        for (int k = 0; k < 4; k++) r[k] = (d[4*k +: 4] == 4'd9);
        return r;
    endfunction

    function automatic logic [3:0] exp_ceo(input logic [15:0] d, input logic en);
        logic [3:0] r;
        logic c;
        c = en;
        for (int k = 0; k < 4; k++) begin
            c = c & (d[4*k +: 4] == 4'd9);
            r[k] = c;
        end
        return r;
    endfunction

    // starts with the DUT in LOAD just after an edge; pause_at > 0 drops CE for 50 cycles after that count
    task automatic run_conv(input logic [15:0] val, input logic [15:0] exp, input int pause_at);
        int nv;
        logic [15:0] hb;
        logic [3:0]  ht;
        logic [15:0] got;
        nv = int'(val);
        I = val;
        step();
        chk("b_after_load", B, val);
        chk("tc_after_load", {12'd0, TC}, 16'd0);
        chk("o_hold_load", O, last_o);
        sb.push_back(exp);
        I = val ^ 16'h5A5A;
        for (int n = 1; n <= nv; n++) begin
            step();
            chk("b_count", B, 16'(nv - n));
            chk("o_hold_count", O, last_o);
            chk("tc_count", {12'd0, TC}, {12'd0, exp_tc(bcd(n))});
            chk("ceo_count", {12'd0, CEO}, {12'd0, exp_ceo(bcd(n), n != nv)});
            if (n == pause_at) begin
                CE = 1'b0;
                hb = B;
                ht = TC;
                for (int p = 0; p < 50; p++) begin
                    step();
                    chk("b_pause", B, hb);
                    chk("tc_pause", {12'd0, TC}, {12'd0, ht});
                    chk("ceo_pause", {12'd0, CEO}, 16'd0);
                    chk("o_pause", O, last_o);
                end
                CE = 1'b1;
            end
        end
        step();
        if (sb.size() == 0) begin
            chk("sb_empty", 16'hDEAD, exp);
        end else begin
            got = sb.pop_front();
            chk("o_latch", O, got);
        end
        chk("tc_latch", {12'd0, TC}, {12'd0, exp_tc(exp)});
        last_o = exp;
    endtask

    initial begin
        vecs[0]  = '{16'h0001, 16'h0001};
        vecs[1]  = '{16'h000A, 16'h0010};
        vecs[2]  = '{16'h001A, 16'h0026};
        vecs[3]  = '{16'h00AA, 16'h0170};
        vecs[4]  = '{16'h00FF, 16'h0255};
        vecs[5]  = '{16'h0000, 16'h0000};
        vecs[6]  = '{16'h0063, 16'h0099};
        vecs[7]  = '{16'h03E7, 16'h0999};
        vecs[8]  = '{16'h270F, 16'h9999};
        vecs[9]  = '{16'h2710, 16'h0000};
        vecs[10] = '{16'h3039, 16'h2345};
        rst = 1'b1;
        CE = 1'b0;
        I = 16'h0000;
        last_o = 16'h0000;
        step();
        step();
        chk("rst_o", O, 16'h0000);
        chk("rst_b", B, 16'h0000);
        chk("rst_tc", {12'd0, TC}, 16'd0);
        chk("rst_ceo", {12'd0, CEO}, 16'd0);
        rst = 1'b0;
        CE = 1'b1;
        for (int v = 0; v < 11; v++) run_conv(vecs[v].i, vecs[v].o, 0);
        run_conv(16'h00FF, 16'h0255, 100);
        I = 16'h0063;
        step();
        for (int n = 0; n < 30; n++) step();
        #2 rst = 1'b1;
        #1;
        chk("midrst_o", O, 16'h0000);
        chk("midrst_b", B, 16'h0000);
        chk("midrst_tc", {12'd0, TC}, 16'd0);
        chk("midrst_ceo", {12'd0, CEO}, 16'd0);
        sb.delete();
        last_o = 16'h0000;
        step();
        step();
        rst = 1'b0;
        run_conv(16'h0063, 16'h0099, 0);
        run_conv(16'h0000, 16'h0000, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
